// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings for the universal shift register.
// Imported by the interface, the register and the bench.
package shift_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle of the universal shift register.
// master drives operations; slave is the register itself.
interface univ_shift_reg_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic              en;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  d;
    logic              sin_r;
    logic              sin_l;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  qbar;
    logic              sout_msb;
    logic              sout_lsb;
    logic [CNT_W-1:0]  shift_cnt;
    logic              word_done;

    modport master (
        output en, mode, d, sin_r, sin_l,
        input  q, qbar, sout_msb, sout_lsb, shift_cnt, word_done
    );

    modport slave (
        input  en, mode, d, sin_r, sin_l,
        output q, qbar, sout_msb, sout_lsb, shift_cnt, word_done
    );

endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with synchronous reset/set,
// per-cycle mode select and a saturating shift counter.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            reset,
    input logic            set,
    univ_shift_reg_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_reg;
    logic             shifting;
    logic             loading;

    always_comb begin
        q_nxt    = q_reg;
        shifting = 1'b0;
        loading  = 1'b0;
        case (bus.mode)
            MODE_SHL: begin
                q_nxt    = {q_reg[WIDTH-2:0], bus.sin_r};
                shifting = 1'b1;
            end
            MODE_SHR: begin
                q_nxt    = {bus.sin_l, q_reg[WIDTH-1:1]};
                shifting = 1'b1;
            end
            MODE_ROL: begin
                q_nxt    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                shifting = 1'b1;
            end
            MODE_ROR: begin
                q_nxt    = {q_reg[0], q_reg[WIDTH-1:1]};
                shifting = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt   = bus.d;
                loading = 1'b1;
            end
            MODE_ASR: begin
                q_nxt    = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
                shifting = 1'b1;
            end
            default: q_nxt = q_reg;
        endcase
    end

    // Counter saturates at WIDTH so word_done stays up until cleared
    always_comb begin
        cnt_nxt = cnt_reg;
        if (loading)
            cnt_nxt = '0;
        else if (shifting && cnt_reg != CNT_MAX)
            cnt_nxt = cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg    <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (!set) begin
            q_reg    <= '1;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (bus.en) begin
            q_reg    <= q_nxt;
            cnt_reg  <= cnt_nxt;
            done_reg <= (cnt_nxt == CNT_MAX);
        end
    end

    assign bus.q         = q_reg;
    assign bus.qbar      = ~q_reg;
    assign bus.sout_msb  = q_reg[WIDTH-1];
    assign bus.sout_lsb  = q_reg[0];
    assign bus.shift_cnt = cnt_reg;
    assign bus.word_done = done_reg;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register; successor to the single-bit synchronous set/reset D flip-flop. Generalises it to WIDTH bits and adds a per-cycle mode select: hold, logical shifts with serial inputs, rotates, arithmetic shift and parallel load. A saturating shift counter flags when a full word has been shifted since the last load. Used as the serialiser/deserialiser and general state register in datapath blocks.

Parameters:
WIDTH, 8, register width in bits; legal 2..64.
CNT_W, $clog2(WIDTH+1), derived localparam; width of the shift counter; not overridable.

Ports:
clk  in  1  clock; all state updates on posedge clk.
reset  in  1  synchronous, active-low; highest priority.
set  in  1  synchronous, active-low; forces q to all ones; below reset.
en  in  1  clock enable for mode operations; does not gate reset or set.
mode  in  3  operation select; encodings in Behaviour.
d  in  WIDTH  parallel load data.
sin_r  in  1  serial in, enters bit 0 on shift left.
sin_l  in  1  serial in, enters bit WIDTH-1 on logical shift right.
q  out  WIDTH  register contents.
qbar  out  WIDTH  continuous bitwise ~q.
sout_msb  out  1  q[WIDTH-1], combinational from q.
sout_lsb  out  1  q[0], combinational from q.
shift_cnt  out  CNT_W  shifts/rotates since last load, set or reset; saturates at WIDTH.
word_done  out  1  registered; 1 exactly when shift_cnt == WIDTH.

Behaviour:
- Priority per posedge: reset==0 > set==0 > en==0 (hold) > mode.
- reset==0: q=0, shift_cnt=0, word_done=0. Value is therefore 0 after the first clock edge with reset low; there is no asynchronous path.
- set==0 with reset==1: q all ones, shift_cnt=0, word_done=0.
- en==0: q, shift_cnt and word_done all hold.
- mode with en==1:
  - 000 HOLD: q holds; shift_cnt holds.
  - 001 SHL: q={q[WIDTH-2:0],sin_r}.
  - 010 SHR: q={sin_l,q[WIDTH-1:1]}.
  - 011 ROL: q={q[WIDTH-2:0],q[WIDTH-1]}.
  - 100 ROR: q={q[0],q[WIDTH-1:1]}.
  - 101 LOAD: q=d; shift_cnt=0; word_done=0.
  - 110 ASR: q={q[WIDTH-1],q[WIDTH-1:1]}.
  - 111 reserved: behaves as HOLD; no state change.
- Modes 001-100 and 110 increment shift_cnt by 1 and saturate at WIDTH (no wrap). word_done is 1 in the cycle after shift_cnt reaches WIDTH and stays 1 until a LOAD, set or reset.
- Latency: one cycle from the sampled inputs to q, shift_cnt and word_done. qbar, sout_msb and sout_lsb follow q combinationally.
- Simultaneous events:
  - reset and set both low: reset wins.
  - set low with en=1 and mode=LOAD: set wins, so q is all ones, not d.
- Reset mid-shift: the counter clears and the partially shifted word is lost; no recovery is required.
- Inputs d, sin_r and sin_l are ignored in modes that do not use them.
- No X propagation: q must be defined after the first reset edge.

Decomposition:
- Shared package shift_pkg:
  - localparams for the mode encodings: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_ASR, MODE_RSVD.
  - localparam MODE_W=3.
- No sub-module required. Next-state logic is a single case on mode. The counter stays inline; it is too small to justify its own module.

Test Plan:
- reset=0 for 2 cycles with set=0 and d=8'hA5 -> q=8'h00, qbar=8'hFF, shift_cnt=0, word_done=0.
- reset=1, set=0, en=0 -> q=8'hFF after 1 clock (set ignores en); shift_cnt=0.
- LOAD d=8'h96, then SHL×8 with sin_r=1 -> q=8'h96,2D,5B,B7,6F,DF,BF,7F,FF. shift_cnt=1..8, word_done=1 after the 8th shift. A 9th shift leaves shift_cnt=8.
- LOAD 8'h81; ROL -> 8'h03; ROR -> 8'h81; ASR -> 8'hC0; SHR with sin_l=0 -> 8'h60. sout_msb/sout_lsb track q at each step.
- LOAD 8'h3C, then mode=111 and en=0 alternating over 4 cycles -> q stays 8'h3C and shift_cnt stays 0.
- Shift 3 times, then assert set=0 concurrently with mode=LOAD d=8'h12 -> q=8'hFF and shift_cnt=0. Then reset=0 with set=0 -> q=8'h00.
